// File: rtl/weight_fetch_controller.sv
// -----------------------------------------------------------------------------
// weight_fetch_controller
//
// Read sequencer that sits directly upstream of the weight block RAM. A start
// command selects a layer. The block then issues one read per cycle for every
// weight of that layer (address 0..COUNT-1) and captures the RAM's registered
// read data into a small skid FIFO. The FIFO head is presented downstream as a
// valid/ready stream of (weight, address, last).
//
// Read requests are credit-limited: a read is issued only while
// occupancy + in-flight + 1 <= FIFO_DEPTH. The 1-cycle RAM latency therefore
// can never overflow the FIFO, whatever the downstream backpressure.
//
// Ports
//   clk, rst_n          clock, synchronous active-low reset
//   i_start, i_layer    start command and layer code (01/10/11), used in IDLE
//   o_busy              high while a fetch is in progress (low in DONE)
//   o_done              one-cycle pulse after the last weight is accepted
//   o_error             one-cycle pulse for a start with layer code 00
//   o_ram_*             RAM read request (enable, rw=1 read, layer, address)
//   i_ram_*             RAM read response (valid, echoed address, data)
//   o_weight_*          output stream (valid, address, last, data)
//   i_weight_ready      output stream ready
// -----------------------------------------------------------------------------
module weight_fetch_controller #(
  parameter int DATA_WIDTH                    = 32,
  parameter int LAYER_WIDTH                   = 2,
  parameter int ADDR_WIDTH                    = 11,
  parameter int NUMBER_OF_INPUT_NODE          = 2,
  parameter int NUMBER_OF_HIDDEN_NODE_LAYER_1 = 32,
  parameter int NUMBER_OF_HIDDEN_NODE_LAYER_2 = 32,
  parameter int NUMBER_OF_OUTPUT_NODE         = 3,
  parameter int FIFO_DEPTH                    = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_start,
  input  logic [LAYER_WIDTH-1:0] i_layer,
  output logic                   o_busy,
  output logic                   o_done,
  output logic                   o_error,
  output logic                   o_ram_enable,
  output logic                   o_ram_rw_select,
  output logic [LAYER_WIDTH-1:0] o_ram_layer,
  output logic [ADDR_WIDTH-1:0]  o_ram_addr,
  input  logic                   i_ram_valid,
  input  logic [ADDR_WIDTH-1:0]  i_ram_addr,
  input  logic [DATA_WIDTH-1:0]  i_ram_weight,
  output logic                   o_weight_valid,
  input  logic                   i_weight_ready,
  output logic [ADDR_WIDTH-1:0]  o_weight_addr,
  output logic                   o_weight_last,
  output logic [DATA_WIDTH-1:0]  o_weight
);

  // ---------------------------------------------------------------------------
  // Derived constants
  // ---------------------------------------------------------------------------
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int OCC_W = PTR_W + 1;   // occupancy must represent FIFO_DEPTH
  localparam int CRD_W = OCC_W + 1;   // room for occupancy + in-flight + 1

  // Weights per layer: nodes x (fan-in + 1 bias)
  localparam logic [ADDR_WIDTH-1:0] CNT_HIDDEN1 =
    ADDR_WIDTH'(NUMBER_OF_HIDDEN_NODE_LAYER_1 * (NUMBER_OF_INPUT_NODE + 1));
  localparam logic [ADDR_WIDTH-1:0] CNT_HIDDEN2 =
    ADDR_WIDTH'(NUMBER_OF_HIDDEN_NODE_LAYER_2 * (NUMBER_OF_HIDDEN_NODE_LAYER_1 + 1));
  localparam logic [ADDR_WIDTH-1:0] CNT_OUTPUT =
    ADDR_WIDTH'(NUMBER_OF_OUTPUT_NODE * (NUMBER_OF_HIDDEN_NODE_LAYER_2 + 1));

  localparam logic [LAYER_WIDTH-1:0] LAYER_HIDDEN1 = LAYER_WIDTH'(1);
  localparam logic [LAYER_WIDTH-1:0] LAYER_HIDDEN2 = LAYER_WIDTH'(2);
  localparam logic [LAYER_WIDTH-1:0] LAYER_OUTPUT  = LAYER_WIDTH'(3);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  function automatic logic [ADDR_WIDTH-1:0] layer_count(
    input logic [LAYER_WIDTH-1:0] layer
  );
    logic [ADDR_WIDTH-1:0] cnt;
    case (layer)
      LAYER_HIDDEN1: cnt = CNT_HIDDEN1;
      LAYER_HIDDEN2: cnt = CNT_HIDDEN2;
      LAYER_OUTPUT:  cnt = CNT_OUTPUT;
      default:       cnt = '0;
    endcase
    return cnt;
  endfunction

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  state_t                 state_q;
  logic [LAYER_WIDTH-1:0] layer_q;
  logic [ADDR_WIDTH-1:0]  issue_cnt_q;   // number of addresses issued so far
  logic                   ram_en_q;
  logic [ADDR_WIDTH-1:0]  ram_addr_q;
  logic                   busy_q;
  logic                   done_q;
  logic                   error_q;

  logic [DATA_WIDTH-1:0]  fifo_weight_q [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0]  fifo_addr_q   [FIFO_DEPTH];
  logic                   fifo_last_q   [FIFO_DEPTH];
  logic [PTR_W-1:0]       wr_ptr_q;
  logic [PTR_W-1:0]       rd_ptr_q;
  logic [OCC_W-1:0]       occ_q;
  logic [OCC_W-1:0]       occ_d;

  // ---------------------------------------------------------------------------
  // Datapath control
  // ---------------------------------------------------------------------------
  logic [ADDR_WIDTH-1:0] cur_count;
  logic                  head_valid;
  logic                  head_last;
  logic                  push;
  logic                  push_last;
  logic                  pop;
  logic                  capture_window;
  logic [CRD_W-1:0]      credit_sum;
  logic                  credit_ok;

  always_comb begin
    cur_count      = layer_count(layer_q);
    head_valid     = (occ_q != '0);
    head_last      = fifo_last_q[rd_ptr_q];
    pop            = head_valid & i_weight_ready;
    capture_window = (state_q == S_FETCH) || (state_q == S_DRAIN);
    // The full guard never blocks a push under the credit rule; it only keeps
    // a misbehaving RAM from overwriting the head.
    push           = i_ram_valid & capture_window &
                     ((occ_q != OCC_W'(FIFO_DEPTH)) | pop);
    push_last      = (i_ram_addr == (cur_count - ADDR_WIDTH'(1)));

    occ_d = occ_q;
    if (push && !pop) begin
      occ_d = occ_q + OCC_W'(1);
    end else if (pop && !push) begin
      occ_d = occ_q - OCC_W'(1);
    end

    // The request decided now goes out next cycle. At that point the
    // occupancy is occ_d and the in-flight read is this cycle's request.
    credit_sum = CRD_W'(occ_d) + CRD_W'(ram_en_q) + CRD_W'(1);
    credit_ok  = (credit_sum <= CRD_W'(FIFO_DEPTH));
  end

  // ---------------------------------------------------------------------------
  // Control FSM with registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      layer_q     <= '0;
      issue_cnt_q <= '0;
      ram_en_q    <= 1'b0;
      ram_addr_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      done_q  <= 1'b0;
      error_q <= 1'b0;

      case (state_q)
        S_IDLE: begin
          ram_en_q <= 1'b0;
          if (i_start) begin
            if (i_layer != '0) begin
              // Address 0 always has credit: the FIFO is empty in IDLE.
              state_q     <= S_FETCH;
              layer_q     <= i_layer;
              busy_q      <= 1'b1;
              ram_en_q    <= 1'b1;
              ram_addr_q  <= '0;
              issue_cnt_q <= ADDR_WIDTH'(1);
            end else begin
              error_q <= 1'b1;
            end
          end
        end

        S_FETCH: begin
          if (issue_cnt_q == cur_count) begin
            // The final address is on the bus this cycle.
            state_q  <= S_DRAIN;
            ram_en_q <= 1'b0;
          end else if (credit_ok) begin
            ram_en_q    <= 1'b1;
            ram_addr_q  <= issue_cnt_q;
            issue_cnt_q <= issue_cnt_q + ADDR_WIDTH'(1);
          end else begin
            ram_en_q <= 1'b0;
          end
        end

        S_DRAIN: begin
          ram_en_q <= 1'b0;
          // The last-flagged entry is the final one of the layer. Once it is
          // the only entry and is accepted, nothing is left in the FIFO or in
          // flight.
          if (pop && head_last && (occ_q == OCC_W'(1)) && !push) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end

        S_DONE: begin
          ram_en_q <= 1'b0;
          state_q  <= S_IDLE;
        end

        default: begin
          state_q  <= S_IDLE;
          ram_en_q <= 1'b0;
          busy_q   <= 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Skid FIFO
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      occ_q <= occ_d;
    end
  end

  // Storage needs no reset: the stream outputs are masked while empty.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_weight_q[wr_ptr_q] <= i_ram_weight;
      fifo_addr_q[wr_ptr_q]   <= i_ram_addr;
      fifo_last_q[wr_ptr_q]   <= push_last;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign o_busy          = busy_q;
  assign o_done          = done_q;
  assign o_error         = error_q;
  assign o_ram_enable    = ram_en_q;
  assign o_ram_rw_select = 1'b1;
  assign o_ram_layer     = layer_q;
  assign o_ram_addr      = ram_addr_q;

  assign o_weight_valid  = head_valid;
  assign o_weight_addr   = head_valid ? fifo_addr_q[rd_ptr_q]   : '0;
  assign o_weight_last   = head_valid & fifo_last_q[rd_ptr_q];
  assign o_weight        = head_valid ? fifo_weight_q[rd_ptr_q] : '0;

endmodule

// File: tb/tb_weight_fetch_controller.sv
// -----------------------------------------------------------------------------
// Bench for weight_fetch_controller. A behavioural RAM returns preloaded
// random weights one cycle after each request. A reference scoreboard expects,
// for each layer, the address sequence 0..COUNT-1 with the matching preloaded
// weight, and last only on COUNT-1. Downstream ready follows a per-run policy.
// -----------------------------------------------------------------------------
module tb_weight_fetch_controller;

  logic        clk;
  logic        rst_n;
  logic        i_start;
  logic [1:0]  i_layer;
  logic        o_busy;
  logic        o_done;
  logic        o_error;
  logic        o_ram_enable;
  logic        o_ram_rw_select;
  logic [1:0]  o_ram_layer;
  logic [10:0] o_ram_addr;
  logic        i_ram_valid;
  logic [10:0] i_ram_addr;
  logic [31:0] i_ram_weight;
  logic        o_weight_valid;
  logic        i_weight_ready;
  logic [10:0] o_weight_addr;
  logic        o_weight_last;
  logic [31:0] o_weight;

  weight_fetch_controller #(
    .DATA_WIDTH(32),
    .LAYER_WIDTH(2),
    .ADDR_WIDTH(11),
    .FIFO_DEPTH(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .i_start(i_start),
    .i_layer(i_layer),
    .o_busy(o_busy),
    .o_done(o_done),
    .o_error(o_error),
    .o_ram_enable(o_ram_enable),
    .o_ram_rw_select(o_ram_rw_select),
    .o_ram_layer(o_ram_layer),
    .o_ram_addr(o_ram_addr),
    .i_ram_valid(i_ram_valid),
    .i_ram_addr(i_ram_addr),
    .i_ram_weight(i_ram_weight),
    .o_weight_valid(o_weight_valid),
    .i_weight_ready(i_weight_ready),
    .o_weight_addr(o_weight_addr),
    .o_weight_last(o_weight_last),
    .o_weight(o_weight)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference state
  logic [31:0] wmem [4][2048];
  int unsigned tests = 0;
  int unsigned fails = 0;
  logic [1:0]  cur_layer = '0;
  int unsigned cur_count = 0;
  int unsigned req_cnt = 0;
  int unsigned acc_cnt = 0;
  int unsigned gaps = 0;
  int unsigned t_start = 0;
  int unsigned fv_cyc = 0;
  int unsigned done_cyc = 0;
  int          mode = 0;        // 0 ready=1, 1 toggle, 2 hold-0 20 cycles, 3 random
  bit          mon_on = 0;
  bit          fv_seen = 0;
  bit          done_seen = 0;
  bit          done_busy = 0;
  bit          prev_hold = 0;
  bit          inj_stale = 0;
  logic [43:0] prev_bundle = '0;

  // RAM pipeline register
  logic        pend_v = 1'b0;
  logic [10:0] pend_a = '0;
  logic [1:0]  pend_l = '0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int unsigned ref_count(input logic [1:0] l);
    case (l)
      2'b01:   return 96;
      2'b10:   return 1056;
      2'b11:   return 99;
      default: return 0;
    endcase
  endfunction

  // Behavioural RAM: request seen in cycle c is answered during cycle c+1.
  always @(negedge clk) begin
    pend_v = o_ram_enable;
    pend_a = o_ram_addr;
    pend_l = o_ram_layer;
  end

  always @(posedge clk) begin
    #1;
    i_ram_valid  = pend_v;
    i_ram_addr   = pend_a;
    i_ram_weight = pend_v ? wmem[pend_l][pend_a] : $urandom;
    if (inj_stale) begin
      i_ram_valid  = 1'b1;
      i_ram_addr   = 11'($urandom);
      i_ram_weight = $urandom;
    end
    if (!fv_seen && o_weight_valid) begin
      fv_seen = 1;
      fv_cyc  = cyc;
    end
    case (mode)
      0:       i_weight_ready = 1'b1;
      1:       i_weight_ready = ~i_weight_ready;
      2:       i_weight_ready = fv_seen && (cyc >= fv_cyc + 20);
      default: i_weight_ready = ($urandom_range(0, 3) != 0);
    endcase
  end

  // Scoreboard / protocol monitor
  always @(negedge clk) begin
    if (mon_on) begin
      if (o_ram_enable) begin
        check_eq("req_addr", 64'(o_ram_addr), 64'(req_cnt));
        check_eq("req_layer", 64'(o_ram_layer), 64'(cur_layer));
        check_eq("req_rw", 64'(o_ram_rw_select), 64'(1));
        check_eq("credit", 64'((req_cnt + 1 - acc_cnt) <= 4), 64'(1));
        req_cnt++;
      end
      if (o_busy && !o_ram_enable && req_cnt > 0 && req_cnt < cur_count) gaps++;
      if (prev_hold) begin
        check_eq("hold_valid", 64'(o_weight_valid), 64'(1));
        check_eq("hold_bundle", 64'({o_weight_addr, o_weight_last, o_weight}), 64'(prev_bundle));
      end
      prev_hold   = o_weight_valid && !i_weight_ready;
      prev_bundle = {o_weight_addr, o_weight_last, o_weight};
      if (o_weight_valid && i_weight_ready) begin
        check_eq("extra_weight", 64'(acc_cnt < cur_count), 64'(1));
        check_eq("w_addr", 64'(o_weight_addr), 64'(acc_cnt));
        check_eq("w_data", 64'(o_weight), 64'(wmem[cur_layer][acc_cnt % 2048]));
        check_eq("w_last", 64'(o_weight_last), 64'(acc_cnt == cur_count - 1));
        acc_cnt++;
      end
      if (mode == 2 && fv_seen && cyc == fv_cyc + 15) begin
        check_eq("stall_reqs", 64'(req_cnt), 64'(4));
        check_eq("stall_en", 64'(o_ram_enable), 64'(0));
        check_eq("stall_valid", 64'(o_weight_valid), 64'(1));
      end
      check_eq("no_error", 64'(o_error), 64'(0));
      if (o_done) begin
        done_seen = 1;
        done_cyc  = cyc;
        done_busy = o_busy;
      end
    end
  end

  task automatic check_reset_state();
    check_eq("rst_busy", 64'(o_busy), 64'(0));
    check_eq("rst_done", 64'(o_done), 64'(0));
    check_eq("rst_error", 64'(o_error), 64'(0));
    check_eq("rst_ram_en", 64'(o_ram_enable), 64'(0));
    check_eq("rst_ram_rw", 64'(o_ram_rw_select), 64'(1));
    check_eq("rst_ram_layer", 64'(o_ram_layer), 64'(0));
    check_eq("rst_ram_addr", 64'(o_ram_addr), 64'(0));
    check_eq("rst_w_valid", 64'(o_weight_valid), 64'(0));
    check_eq("rst_w_addr", 64'(o_weight_addr), 64'(0));
    check_eq("rst_w_last", 64'(o_weight_last), 64'(0));
    check_eq("rst_w_data", 64'(o_weight), 64'(0));
  endtask

  task automatic arm(input logic [1:0] l, input int m);
    cur_layer = l;
    cur_count = ref_count(l);
    req_cnt   = 0;
    acc_cnt   = 0;
    gaps      = 0;
    done_seen = 0;
    fv_seen   = 0;
    prev_hold = 0;
    mode      = m;
    mon_on    = 1;
  endtask

  task automatic pulse_start(input logic [1:0] l);
    @(posedge clk);
    #1;
    i_start = 1'b1;
    i_layer = l;
    t_start = cyc;
    @(posedge clk);
    #1;
    i_start = 1'b0;
    i_layer = 2'($urandom);
  endtask

  task automatic run_layer(input logic [1:0] l, input int m, input bit dup);
    int unsigned n;
    arm(l, m);
    pulse_start(l);
    @(negedge clk);
    check_eq("start_busy", 64'(o_busy), 64'(1));
    check_eq("start_req", 64'(o_ram_enable), 64'(1));
    n = 0;
    while (!done_seen && n < 6000) begin
      @(negedge clk);
      n++;
      if (dup && n == 30) begin
        @(posedge clk);
        #1;
        i_start = 1'b1;
        i_layer = 2'b10;
        @(posedge clk);
        #1;
        i_start = 1'b0;
      end
    end
    check_eq("done_seen", 64'(done_seen), 64'(1));
    check_eq("acc_count", 64'(acc_cnt), 64'(cur_count));
    check_eq("req_count", 64'(req_cnt), 64'(cur_count));
    check_eq("done_busy", 64'(done_busy), 64'(0));
    if (m == 0) begin
      check_eq("first_valid_cyc", 64'(fv_cyc), 64'(t_start + 3));
      check_eq("done_cyc", 64'(done_cyc), 64'(t_start + 3 + cur_count));
      check_eq("no_gaps", 64'(gaps), 64'(0));
    end
    if (m == 1) check_eq("gaps_seen", 64'(gaps > 0), 64'(1));
    @(negedge clk);
    check_eq("done_pulse", 64'(o_done), 64'(0));
    check_eq("idle_busy", 64'(o_busy), 64'(0));
    mon_on = 0;
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int unsigned n;
    rst_n          = 1'b0;
    i_start        = 1'b0;
    i_layer        = 2'b00;
    i_ram_valid    = 1'b0;
    i_ram_addr     = '0;
    i_ram_weight   = '0;
    i_weight_ready = 1'b0;
    for (int l = 0; l < 4; l++)
      for (int a = 0; a < 2048; a++)
        wmem[l][a] = $urandom;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_state();
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Layer 01, ready held high: exact latency and throughput
    run_layer(2'b01, 0, 0);
    // Layer 10, ready toggling: backpressure and credit gaps
    run_layer(2'b10, 1, 0);
    // Layer 11, ready low for 20 cycles after first valid
    run_layer(2'b11, 2, 0);

    // Start with layer 00
    @(posedge clk);
    #1;
    i_start = 1'b1;
    i_layer = 2'b00;
    @(posedge clk);
    #1;
    i_start = 1'b0;
    @(negedge clk);
    check_eq("err_pulse", 64'(o_error), 64'(1));
    check_eq("err_busy", 64'(o_busy), 64'(0));
    check_eq("err_req", 64'(o_ram_enable), 64'(0));
    @(negedge clk);
    check_eq("err_single", 64'(o_error), 64'(0));
    check_eq("err_busy2", 64'(o_busy), 64'(0));
    check_eq("err_req2", 64'(o_ram_enable), 64'(0));

    // Second start mid-fetch is ignored
    run_layer(2'b01, 0, 1);

    // Reset mid-fetch of layer 11 at weight 40
    arm(2'b11, 0);
    pulse_start(2'b11);
    n = 0;
    while (acc_cnt < 40 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check_eq("reach_w40", 64'(acc_cnt >= 40), 64'(1));
    mon_on = 0;
    @(posedge clk);
    #1;
    rst_n     = 1'b0;
    inj_stale = 1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_state();
    @(negedge clk);
    check_eq("stale_valid", 64'(o_weight_valid), 64'(0));
    check_eq("stale_busy", 64'(o_busy), 64'(0));
    check_eq("stale_req", 64'(o_ram_enable), 64'(0));
    inj_stale = 0;
    run_layer(2'b01, 0, 0);

    // Layer 11 with random backpressure
    run_layer(2'b11, 3, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
